// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the E-stage multiply/divide unit.
// Provides the md operation encodings and the unit's FSM state type.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational multiply/divide result generator.
// Ports: op (md operation), a (rs), b (rt) -> res_hi/res_lo (HI/LO result pair).
// MTHI/MTLO results are don't-care; the caller never latches them from here.
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   dsor_s, dsor_u, q_s, r_s, q_u, r_u;
    logic               b_zero, ovf;

    assign b_zero = b == '0;
    assign ovf    = (a == MOST_NEG) && (b == '1);

    // Divisors are steered to 1 in the cases whose results are overridden,
    // so the dividers never see a zero or overflowing operand pair.
    assign dsor_s = (b_zero || ovf) ? ONE : b;
    assign dsor_u = b_zero ? ONE : b;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign q_s    = $signed(a) / $signed(dsor_s);
    assign r_s    = $signed(a) % $signed(dsor_s);
    assign q_u    = a / dsor_u;
    assign r_u    = a % dsor_u;

    always_comb begin
        res_hi = op == MD_MULT  ? prod_s[2*WIDTH-1:WIDTH] :
                 op == MD_MULTU ? prod_u[2*WIDTH-1:WIDTH] :
                 b_zero         ? a :
                 op == MD_DIV   ? (ovf ? '0 : r_s) : r_u;
        res_lo = op == MD_MULT  ? prod_s[WIDTH-1:0] :
                 op == MD_MULTU ? prod_u[WIDTH-1:0] :
                 b_zero         ? '1 :
                 op == MD_DIV   ? (ovf ? a : q_s) : q_u;
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Ports: clk, reset (async active-low), start/op/a/b (E-stage md instruction),
//        flush (abort in-flight op), busy (op in flight), hi/lo (HI/LO registers).
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1;

    md_state_e        state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi, pend_lo, res_hi, res_lo;
    logic             idle_go, accept, commit;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Any start coinciding with flush is dropped, including MTHI/MTLO.
    assign idle_go = state == IDLE && start && !flush;
    assign accept  = idle_go && op < MD_MTHI;
    assign commit  = state == RUN && !flush && cnt == '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (accept ? RUN : IDLE) :
                    (flush || cnt == '0) ? IDLE : RUN;
    end

    always_comb begin
        busy = state == RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (accept) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= op < MD_DIV ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
            end else if (state == RUN) begin
                cnt <= (flush || cnt == '0) ? '0 : cnt - 1'b1;
            end
            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (idle_go && op == MD_MTHI) hi <= a;
            if (idle_go && op == MD_MTLO) lo <= a;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit with hand-computed results.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n,
                          input logic [31:0] eh, input logic [31:0] el);
        issue(o, x, y);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            @(negedge clk);
        end
        chk({tag, "_done"}, {31'b0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negb", MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 32'd7, 32'hFFFFFFFF);
        run_op("div_zero", MD_DIV, 32'hFFFFFFF9, 32'd0, 10, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        run_op("divu_big", MD_DIVU, 32'h80000000, 32'hFFFFFFFF, 10, 32'h80000000, 32'h00000000);

        issue(MD_MTHI, 32'h12345678, 32'd0);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo", lo, 32'h00000000);
        issue(MD_MTLO, 32'h0000CAFE, 32'd0);
        chk("mtlo_lo", lo, 32'h0000CAFE);
        chk("mtlo_hi", hi, 32'h12345678);

        // DIV 100/7 = 14 r 2; a MULT 5*5 offered during RUN must be dropped
        issue(MD_DIV, 32'd100, 32'd7);
        @(negedge clk);
        issue(MD_MULT, 32'd5, 32'd5);
        repeat (7) @(negedge clk);
        chk("ign_busy9", {31'b0, busy}, 32'd1);
        chk("ign_hold_hi", hi, 32'h12345678);
        @(negedge clk);
        chk("ign_done", {31'b0, busy}, 32'd0);
        chk("ign_hi", hi, 32'd2);
        chk("ign_lo", lo, 32'd14);
        @(negedge clk);
        chk("ign_idle", {31'b0, busy}, 32'd0);
        chk("ign_hi2", hi, 32'd2);

        issue(MD_MTHI, 32'hA, 32'd0);
        issue(MD_MTLO, 32'hB, 32'd0);
        issue(MD_MULT, 32'd3, 32'd3);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush3_busy", {31'b0, busy}, 32'd0);
        chk("flush3_hi", hi, 32'hA);
        chk("flush3_lo", lo, 32'hB);
        repeat (5) @(negedge clk);
        chk("flush3_late_lo", lo, 32'hB);

        issue(MD_MULT, 32'd3, 32'd3);
        repeat (4) @(negedge clk);
        chk("flushc_busy_pre", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flushc_busy", {31'b0, busy}, 32'd0);
        chk("flushc_hi", hi, 32'hA);
        chk("flushc_lo", lo, 32'hB);

        flush = 1'b1;
        issue(MD_MULT, 32'd3, 32'd3);
        chk("flush_start_busy", {31'b0, busy}, 32'd0);
        issue(MD_MTHI, 32'h55, 32'd0);
        flush = 1'b0;
        chk("flush_mthi_hi", hi, 32'hA);

        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        repeat (12) @(negedge clk);
        chk("arst_stay_lo", lo, 32'd0);
        run_op("multu_small", MD_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
